segment_window_scheduler: RTL and testbench

- Frame-level controller for the six-digit capture region of the VGA pixel path.
- Generates the registered window mask and blanks pixels outside the six digit windows.
- Accumulates a per-window foreground pixel count over each frame.
- After the region closes, hands the six counts to the downstream digit classifier one at a time over a valid/ready handshake.

---
 rtl/segment_window_scheduler.sv | 241 ++++++++++++++++++++++++
 tb/tb_segment_window_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_window_scheduler.sv
// ---------------------------------------------------------------------------
// segment_window_scheduler
//
// Frame-level controller for the six-digit capture region of the VGA pixel
// path. It masks the pixel stream down to the six digit windows, counts
// foreground pixels per window over a frame, and once the region has been
// scanned hands the six counts to the digit classifier one at a time over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   pix_en              pixel strobe; hcnt/vcnt/pixel_in valid when high
//   enable              run enable, sampled only at frame start
//   hcnt, vcnt          raster position of pixel_in
//   pixel_in            RGB444 pixel {R,G,B}
//   threshold           foreground when R+G+B < threshold
//   pixel_out           registered masked pixel (0 outside the windows)
//   win_active, win_idx registered window hit and index (7 = no window)
//   res_valid/res_ready result handshake
//   res_idx, res_count  window index and count of the presented result
//   frame_done          pulse after the sixth result is accepted
//   overrun             pulse when a frame start aborts an unfinished report
//   busy                high while accumulating or reporting
// ---------------------------------------------------------------------------
module segment_window_scheduler #(
    parameter int V_TOP = 150,
    parameter int V_BOT = 300,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    input  logic             enable,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    input  logic [11:0]      pixel_in,
    input  logic [5:0]       threshold,
    output logic [11:0]      pixel_out,
    output logic             win_active,
    output logic [2:0]       win_idx,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_idx,
    output logic [CNT_W-1:0] res_count,
    output logic             frame_done,
    output logic             overrun,
    output logic             busy
);

    localparam logic [2:0] NO_WIN   = 3'd7;
    localparam logic [2:0] LAST_IDX = 3'd5;
    localparam logic [9:0] ROW_TOP  = 10'(V_TOP);
    localparam logic [9:0] ROW_BOT  = 10'(V_BOT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Window index for a raster position; all bounds are exclusive.
    function automatic logic [2:0] windowOf(input logic [9:0] h, input logic [9:0] v);
        logic [2:0] idx;
        idx = NO_WIN;
        if (v > ROW_TOP && v < ROW_BOT) begin
            if      (h > 10'd50  && h < 10'd125) idx = 3'd0;
            else if (h > 10'd140 && h < 10'd215) idx = 3'd1;
            else if (h > 10'd230 && h < 10'd305) idx = 3'd2;
            else if (h > 10'd335 && h < 10'd410) idx = 3'd3;
            else if (h > 10'd425 && h < 10'd500) idx = 3'd4;
            else if (h > 10'd515 && h < 10'd590) idx = 3'd5;
        end
        return idx;
    endfunction

    // Saturating increment: a full counter stays at all-ones.
    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] a);
        return (&a) ? a : a + 1'b1;
    endfunction

    // Sum of three 4-bit channels never exceeds 45, so 6 bits cannot wrap.
    function automatic logic isForeground(input logic [11:0] p, input logic [5:0] thr);
        logic [5:0] sum;
        sum = {2'b00, p[11:8]} + {2'b00, p[7:4]} + {2'b00, p[3:0]};
        return sum < thr;
    endfunction

    state_t           state;
    state_t           stateNext;
    logic [2:0]       curWin;
    logic             curFg;
    logic             frameStart;
    logic             reportTrig;
    logic             accept;
    logic             clearAcc;
    logic             countEn;
    logic             loadFirst;
    logic             advance;
    logic             finish;
    logic             abort;
    logic [2:0]       nextIdx;
    logic [CNT_W-1:0] nextCount;
    logic [CNT_W-1:0] acc [6];

    logic [11:0]      pixOut_p1;
    logic             winActive_p1;
    logic [2:0]       winIdx_p1;

    assign curWin     = windowOf(hcnt, vcnt);
    assign curFg      = isForeground(pixel_in, threshold);
    assign frameStart = pix_en && (hcnt == 10'd0) && (vcnt == 10'd0);
    assign reportTrig = pix_en && (hcnt == 10'd0) && (vcnt == ROW_BOT);
    assign accept     = res_valid && res_ready;

    // ---- stage p0 -> p1: window mask (runs in every FSM state) ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixOut_p1    <= 12'h000;
            winActive_p1 <= 1'b0;
            winIdx_p1    <= NO_WIN;
        end else if (pix_en) begin
            pixOut_p1    <= (curWin != NO_WIN) ? pixel_in : 12'h000;
            winActive_p1 <= (curWin != NO_WIN);
            winIdx_p1    <= curWin;
        end
    end

    assign pixel_out  = pixOut_p1;
    assign win_active = winActive_p1;
    assign win_idx    = winIdx_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        clearAcc  = 1'b0;
        countEn   = 1'b0;
        loadFirst = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (frameStart && enable) begin
                    clearAcc  = 1'b1;
                    stateNext = ACCUM;
                end
            end
            ACCUM: begin
                if (frameStart) begin
                    // Frame restarted before the region closed: start over.
                    clearAcc = 1'b1;
                end else if (reportTrig) begin
                    loadFirst = 1'b1;
                    stateNext = REPORT;
                end else begin
                    countEn = pix_en && (curWin != NO_WIN) && curFg;
                end
            end
            REPORT: begin
                // A frame start wins over a same-cycle acceptance.
                if (frameStart) begin
                    abort     = 1'b1;
                    clearAcc  = 1'b1;
                    stateNext = enable ? ACCUM : IDLE;
                end else if (accept) begin
                    if (res_idx == LAST_IDX) begin
                        finish    = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 6; k++) begin
                acc[k] <= '0;
            end
        end else if (clearAcc) begin
            for (int k = 0; k < 6; k++) begin
                acc[k] <= '0;
            end
        end else if (countEn) begin
            for (int k = 0; k < 6; k++) begin
                if (curWin == 3'(k)) begin
                    acc[k] <= satInc(acc[k]);
                end
            end
        end
    end

    always_comb begin
        nextIdx   = res_idx + 3'd1;
        nextCount = '0;
        for (int k = 0; k < 6; k++) begin
            if (nextIdx == 3'(k)) begin
                nextCount = acc[k];
            end
        end
    end

    // ---- result stage: res_idx doubles as the report pointer ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid  <= 1'b0;
            res_idx    <= 3'd0;
            res_count  <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= finish;
            overrun    <= abort;
            if (loadFirst) begin
                res_valid <= 1'b1;
                res_idx   <= 3'd0;
                res_count <= acc[0];
            end else if (abort || finish) begin
                res_valid <= 1'b0;
            end else if (advance) begin
                res_idx   <= nextIdx;
                res_count <= nextCount;
            end
        end
    end

endmodule

// File: tb/tb_segment_window_scheduler.sv
// ---------------------------------------------------------------------------
// tb_segment_window_scheduler
//
// Randomized bench for segment_window_scheduler. A compact behavioural model
// (per-window counters, an abstract idle/accumulate/report mode and the next
// expected result index) is advanced alongside every clock and compared with
// the DUT each cycle. A second instance with a 3-bit count width shares all
// inputs so that counter saturation is exercised. The region is shortened
// (V_BOT=162) to keep frames small while covering every window.
// ---------------------------------------------------------------------------
module tb_segment_window_scheduler;

    localparam int VT   = 150;
    localparam int VB   = 162;
    localparam int CW   = 14;
    localparam int SW   = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int MAXS = (1 << SW) - 1;
    localparam logic [15:0] MASK_RST = {1'b0, 3'd7, 12'h000};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pixEn;
    logic          enable;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic [11:0]   pixelIn;
    logic [5:0]    threshold;
    logic          resReady;

    logic [11:0]   pixelOut,  pixelOutS;
    logic          winActive, winActiveS;
    logic [2:0]    winIdx,    winIdxS;
    logic          resValid,  resValidS;
    logic [2:0]    resIdx,    resIdxS;
    logic [CW-1:0] resCount;
    logic [SW-1:0] resCountS;
    logic          frameDone, frameDoneS;
    logic          overrun,   overrunS;
    logic          busy,      busyS;

    int nChecks = 0;
    int nErr    = 0;

    // Behavioural model state
    int          mode;      // 0 idle, 1 accumulating, 2 reporting
    int          nextIdx;
    int          cnt [6];
    logic [15:0] expMask;
    int          winLo [6] = '{50, 140, 230, 335, 425, 515};

    always #5 clk = ~clk;

    segment_window_scheduler #(.V_TOP(VT), .V_BOT(VB), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pixEn), .enable(enable),
        .hcnt(hcnt), .vcnt(vcnt), .pixel_in(pixelIn), .threshold(threshold),
        .pixel_out(pixelOut), .win_active(winActive), .win_idx(winIdx),
        .res_valid(resValid), .res_ready(resReady), .res_idx(resIdx),
        .res_count(resCount), .frame_done(frameDone), .overrun(overrun),
        .busy(busy)
    );

    segment_window_scheduler #(.V_TOP(VT), .V_BOT(VB), .CNT_W(SW)) dutSat (
        .clk(clk), .rst_n(rst_n), .pix_en(pixEn), .enable(enable),
        .hcnt(hcnt), .vcnt(vcnt), .pixel_in(pixelIn), .threshold(threshold),
        .pixel_out(pixelOutS), .win_active(winActiveS), .win_idx(winIdxS),
        .res_valid(resValidS), .res_ready(resReady), .res_idx(resIdxS),
        .res_count(resCountS), .frame_done(frameDoneS), .overrun(overrunS),
        .busy(busyS)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int winOf(input int h, input int v);
        if (v <= VT || v >= VB) return 7;
        for (int k = 0; k < 6; k++) begin
            if (h > winLo[k] && h < winLo[k] + 75) return k;
        end
        return 7;
    endfunction

    function automatic bit isFg(input logic [11:0] p, input logic [5:0] thr);
        int s;
        s = int'(p[11:8]) + int'(p[7:4]) + int'(p[3:0]);
        return s < int'(thr);
    endfunction

    function automatic logic [11:0] pixFor(input int kind, input int h, input int v);
        if (kind == 0) return 12'h000;
        if (kind == 1) return (winOf(h, v) == 3 && v >= 151 && v <= 160) ? 12'h000 : 12'hFFF;
        return 12'($urandom);
    endfunction

    task automatic clearModel();
        for (int k = 0; k < 6; k++) cnt[k] = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven,
    // clock the DUT, then compare every observable output.
    task automatic step();
        logic       fs, trig, expFd, expOv;
        logic [3:0] expSt;
        int         w;
        fs    = pixEn && hcnt == 10'd0 && vcnt == 10'd0;
        trig  = pixEn && hcnt == 10'd0 && int'(vcnt) == VB;
        w     = winOf(int'(hcnt), int'(vcnt));
        expFd = 1'b0;
        expOv = 1'b0;
        case (mode)
            0: begin
                if (fs && enable) begin clearModel(); mode = 1; end
            end
            1: begin
                if (fs) clearModel();
                else if (trig) begin mode = 2; nextIdx = 0; end
                else if (pixEn && w != 7 && isFg(pixelIn, threshold))
                    cnt[w] = (cnt[w] < MAXC) ? cnt[w] + 1 : cnt[w];
            end
            default: begin
                if (fs) begin
                    expOv = 1'b1;
                    clearModel();
                    mode = enable ? 1 : 0;
                end else if (resReady) begin
                    if (nextIdx == 5) begin expFd = 1'b1; mode = 0; end
                    else nextIdx++;
                end
            end
        endcase
        if (pixEn) expMask = (w == 7) ? MASK_RST : {1'b1, 3'(w), pixelIn};
        expSt = {mode != 0, mode == 2, expFd, expOv};

        @(posedge clk);
        #1;
        chk("mask",    {winActive, winIdx, pixelOut}, expMask);
        chk("maskSat", {winActiveS, winIdxS, pixelOutS}, expMask);
        chk("status",    {busy, resValid, frameDone, overrun}, expSt);
        chk("statusSat", {busyS, resValidS, frameDoneS, overrunS}, expSt);
        if (mode == 2) begin
            chk("resIdx",    resIdx, nextIdx);
            chk("resIdxSat", resIdxS, nextIdx);
            chk("resCount",  resCount, cnt[nextIdx]);
            chk("resCountSat", resCountS, (cnt[nextIdx] < MAXS) ? cnt[nextIdx] : MAXS);
        end
    endtask

    task automatic resetChecks(input string tag);
        chk({tag, "Mask"},   {winActive, winIdx, pixelOut}, MASK_RST);
        chk({tag, "Status"}, {busy, resValid, frameDone, overrun}, 0);
        chk({tag, "Res"},    {resIdx, resCount}, 0);
        chk({tag, "MaskSat"},   {winActiveS, winIdxS, pixelOutS}, MASK_RST);
        chk({tag, "StatusSat"}, {busyS, resValidS, frameDoneS, overrunS}, 0);
        chk({tag, "ResSat"},    {resIdxS, resCountS}, 0);
    endtask

    // Reset is asserted between clock edges and checked before the next edge.
    task automatic asyncReset();
        #3 rst_n = 1'b0;
        #1;
        resetChecks("asyncRst");
        mode    = 0;
        nextIdx = 0;
        clearModel();
        expMask = MASK_RST;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One pixel, occasionally preceded by an idle strobe-low cycle carrying junk.
    task automatic px(input logic [9:0] h, input logic [9:0] v, input logic [11:0] p);
        if ($urandom_range(15) == 0) begin
            pixEn   = 1'b0;
            hcnt    = 10'($urandom);
            vcnt    = 10'($urandom);
            pixelIn = 12'($urandom);
            step();
        end
        pixEn   = 1'b1;
        hcnt    = h;
        vcnt    = v;
        pixelIn = p;
        step();
        pixEn = 1'b0;
    endtask

    task automatic driveFrame(input int kind, input int resetAfter);
        int n;
        n = 0;
        enable = 1'b1;
        px(10'd0, 10'd0, pixFor(kind, 0, 0));
        for (int v = VT; v < VB; v++) begin
            if (v == VT + 4) enable = 1'b0;
            for (int h = 0; h < 600; h++) begin
                if (n == resetAfter) begin
                    asyncReset();
                    enable = 1'b1;
                    return;
                end
                px(10'(h), 10'(v), pixFor(kind, h, v));
                n++;
            end
        end
        enable = 1'b1;
        px(10'd0, 10'(VB), 12'h000);
    endtask

    task automatic drain(input int stallIdx, input int stallLen, input bit rnd, input int stopAfter);
        int stalled, guard, done;
        stalled = 0;
        guard   = 0;
        done    = 0;
        while (mode == 2 && guard < 400 && done < stopAfter) begin
            if (nextIdx == stallIdx && stalled < stallLen) begin
                resReady = 1'b0;
                stalled++;
            end else begin
                resReady = rnd ? 1'($urandom_range(1)) : 1'b1;
            end
            if (resReady) done++;
            step();
            guard++;
        end
        if (guard >= 400) chk("drainBound", 32'(guard), 32'd0);
        resReady = 1'b0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pixEn = 1'b0; enable = 1'b0; hcnt = '0; vcnt = '0;
        pixelIn = '0; threshold = 6'd6; resReady = 1'b0;
        mode = 0; nextIdx = 0; clearModel(); expMask = MASK_RST;
        repeat (3) @(posedge clk);
        #1;
        resetChecks("rst");
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed mask points while idle
        px(10'd51, 10'd151, 12'hFFF);
        chk("tpW0pix", pixelOut, 12'hFFF);
        chk("tpW0idx", winIdx, 3'd0);
        px(10'd125, 10'd151, 12'hFFF);
        chk("tpEdgePix", pixelOut, 12'h000);
        chk("tpEdgeIdx", winIdx, 3'd7);
        px(10'd516, 10'd151, 12'hFFF);
        chk("tpW5idx", winIdx, 3'd5);
        px(10'd51, 10'(VB), 12'hFFF);
        chk("tpRowPix", pixelOut, 12'h000);

        // All-dark frame, back-to-back acceptance
        threshold = 6'd6;
        driveFrame(0, -1);
        drain(-1, 0, 1'b0, 6);

        // Only window 3 dark in rows 151..160, stall at index 2
        driveFrame(1, -1);
        drain(2, 20, 1'b0, 6);

        // Random frame, two results taken, then a new frame aborts the report
        threshold = 6'($urandom_range(8, 40));
        driveFrame(2, -1);
        drain(-1, 0, 1'b0, 2);
        repeat (8) step();
        threshold = 6'($urandom_range(8, 40));
        driveFrame(2, -1);

        // Abort with a same-cycle acceptance and enable low: back to idle
        drain(-1, 0, 1'b1, 1);
        resReady = 1'b1;
        enable   = 1'b0;
        px(10'd0, 10'd0, 12'h000);
        resReady = 1'b0;
        enable   = 1'b1;
        step();

        // threshold 0 counts nothing
        threshold = 6'd0;
        driveFrame(0, -1);
        drain(-1, 0, 1'b1, 6);

        // Reset in the middle of accumulation, then a random frame
        threshold = 6'd6;
        driveFrame(0, 3000);
        threshold = 6'($urandom_range(8, 40));
        driveFrame(2, -1);

        // Reset in the middle of the report, then a clean frame
        drain(-1, 0, 1'b0, 3);
        asyncReset();
        threshold = 6'd6;
        driveFrame(0, -1);
        drain(-1, 0, 1'b1, 6);

        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end

endmodule
